// File: rtl/dp_ram_pkg.sv
// rtl/dp_ram_pkg.sv - shared constants and depth helper for the dual-port RAM FIFO
package dp_ram_pkg;

    localparam int DP_RAM_DATA_W = 8;
    localparam int DP_RAM_ADDR_W = 11;

    function automatic int dp_ram_depth(input int addr_w);
        return 1 << addr_w;
    endfunction

endpackage

// File: rtl/dp_ram_mem.sv
// rtl/dp_ram_mem.sv - simple dual-port RAM, synchronous write, asynchronous read, no reset
module dp_ram_mem #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 11
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [0:(2**ADDR_W)-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/dp_ram_fifo.sv
// rtl/dp_ram_fifo.sv - FWFT AXI4-Stream FIFO over dual-port RAM with occupancy count
// Optional status outputs (full, empty, sticky overflow) with DP_RAM_STATUS_EN.
module dp_ram_fifo
    import dp_ram_pkg::*;
#(
    parameter int DATA_W = DP_RAM_DATA_W,
    parameter int ADDR_W = DP_RAM_ADDR_W,
    parameter int CNT_W  = ADDR_W + 1
) (
    input  logic              s_aclk,
    input  logic              s_aresetn,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    input  logic [DATA_W-1:0] s_axis_tdata,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic [CNT_W-1:0]  axis_data_count
`ifdef DP_RAM_STATUS_EN
    ,
    output logic              full,
    output logic              empty,
    output logic              overflow
`endif
);

    localparam int               DEPTH     = dp_ram_depth(ADDR_W);
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              wr_en;
    logic              rd_en;

    assign s_axis_tready   = (count != DEPTH_CNT);
    assign m_axis_tvalid   = (count != '0);
    assign axis_data_count = count;
    assign wr_en           = s_axis_tvalid && s_axis_tready;
    assign rd_en           = m_axis_tvalid && m_axis_tready;

    // Pointers wrap naturally at DEPTH; count disambiguates full from empty.
    always_ff @(posedge s_aclk or negedge s_aresetn) begin
        if (!s_aresetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + ADDR_W'(1);
            end
            case ({wr_en, rd_en})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    dp_ram_mem #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk   (s_aclk),
        .we    (wr_en),
        .waddr (wr_ptr),
        .wdata (s_axis_tdata),
        .raddr (rd_ptr),
        .rdata (m_axis_tdata)
    );

`ifdef DP_RAM_STATUS_EN
    assign full  = (count == DEPTH_CNT);
    assign empty = (count == '0);

    always_ff @(posedge s_aclk or negedge s_aresetn) begin
        if (!s_aresetn) begin
            overflow <= 1'b0;
        end else if (s_axis_tvalid && full) begin
            overflow <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_dp_ram_fifo.sv
// tb/tb_dp_ram_fifo.sv - directed self-checking bench for dp_ram_fifo
module tb_dp_ram_fifo;

    logic        s_aclk;
    logic        s_aresetn;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic [7:0]  s_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic [7:0]  m_axis_tdata;
    logic [11:0] axis_data_count;
`ifdef DP_RAM_STATUS_EN
    logic        full;
    logic        empty;
    logic        overflow;
`endif

    int passed;
    int total;

    dp_ram_fifo dut (
        .s_aclk          (s_aclk),
        .s_aresetn       (s_aresetn),
        .s_axis_tvalid   (s_axis_tvalid),
        .s_axis_tready   (s_axis_tready),
        .s_axis_tdata    (s_axis_tdata),
        .m_axis_tvalid   (m_axis_tvalid),
        .m_axis_tready   (m_axis_tready),
        .m_axis_tdata    (m_axis_tdata),
        .axis_data_count (axis_data_count)
`ifdef DP_RAM_STATUS_EN
        ,
        .full            (full),
        .empty           (empty),
        .overflow        (overflow)
`endif
    );

    initial s_aclk = 1'b0;
    always #5 s_aclk = ~s_aclk;

    task automatic tick;
        @(posedge s_aclk);
        @(negedge s_aclk);
    endtask

    task automatic test_reset;
        s_aresetn = 1'b0;
        tick();
        tick();
        total++; if (axis_data_count !== 12'd0) $display("FAIL reset_count: got %0d expected 0", axis_data_count); else passed++;
        total++; if (m_axis_tvalid !== 1'b0) $display("FAIL reset_mvalid: got %b expected 0", m_axis_tvalid); else passed++;
        total++; if (s_axis_tready !== 1'b1) $display("FAIL reset_sready: got %b expected 1", s_axis_tready); else passed++;
`ifdef DP_RAM_STATUS_EN
        total++; if (empty !== 1'b1 || full !== 1'b0 || overflow !== 1'b0) $display("FAIL reset_status: got e%b f%b o%b expected e1 f0 o0", empty, full, overflow); else passed++;
`endif
        s_aresetn = 1'b1;
        tick();
        s_axis_tvalid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            s_axis_tdata = 8'(i);
            tick();
        end
        total++; if (axis_data_count !== 12'd5) $display("FAIL pre_reset_count: got %0d expected 5", axis_data_count); else passed++;
        s_axis_tdata = 8'h55;
        #2 s_aresetn = 1'b0;
        #1;
        total++; if (axis_data_count !== 12'd0) $display("FAIL async_reset_count: got %0d expected 0", axis_data_count); else passed++;
        total++; if (m_axis_tvalid !== 1'b0) $display("FAIL async_reset_mvalid: got %b expected 0", m_axis_tvalid); else passed++;
        total++; if (s_axis_tready !== 1'b1) $display("FAIL async_reset_sready: got %b expected 1", s_axis_tready); else passed++;
        tick();
        s_axis_tvalid = 1'b0;
        s_aresetn = 1'b1;
        tick();
        total++; if (axis_data_count !== 12'd0) $display("FAIL post_reset_count: got %0d expected 0", axis_data_count); else passed++;
    endtask

    task automatic test_fwft;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = 8'hA5;
        #1;
        total++; if (m_axis_tvalid !== 1'b0) $display("FAIL fwft_no_bypass: got %b expected 0", m_axis_tvalid); else passed++;
        tick();
        s_axis_tvalid = 1'b0;
        total++; if (m_axis_tvalid !== 1'b1) $display("FAIL fwft_mvalid: got %b expected 1", m_axis_tvalid); else passed++;
        total++; if (m_axis_tdata !== 8'hA5) $display("FAIL fwft_data: got %h expected a5", m_axis_tdata); else passed++;
        total++; if (axis_data_count !== 12'd1) $display("FAIL fwft_count: got %0d expected 1", axis_data_count); else passed++;
        tick();
        total++; if (m_axis_tdata !== 8'hA5) $display("FAIL fwft_hold: got %h expected a5", m_axis_tdata); else passed++;
        m_axis_tready = 1'b1;
        tick();
        m_axis_tready = 1'b0;
        total++; if (axis_data_count !== 12'd0) $display("FAIL fwft_pop_count: got %0d expected 0", axis_data_count); else passed++;
        total++; if (m_axis_tvalid !== 1'b0) $display("FAIL fwft_pop_mvalid: got %b expected 0", m_axis_tvalid); else passed++;
    endtask

    task automatic test_burst;
        s_axis_tvalid = 1'b1;
        for (int i = 0; i < 256; i++) begin
            s_axis_tdata = 8'(i);
            tick();
        end
        s_axis_tvalid = 1'b0;
        total++; if (axis_data_count !== 12'd256) $display("FAIL burst_peak: got %0d expected 256", axis_data_count); else passed++;
        m_axis_tready = 1'b1;
        for (int i = 0; i < 256; i++) begin
            total++; if (m_axis_tdata !== 8'(i) || m_axis_tvalid !== 1'b1) $display("FAIL burst_order[%0d]: got %h/%b expected %h/1", i, m_axis_tdata, m_axis_tvalid, 8'(i)); else passed++;
            tick();
        end
        m_axis_tready = 1'b0;
        total++; if (axis_data_count !== 12'd0) $display("FAIL burst_drained: got %0d expected 0", axis_data_count); else passed++;
    endtask

    task automatic test_full;
        s_axis_tvalid = 1'b1;
        for (int i = 0; i < 2048; i++) begin
            s_axis_tdata = 8'(i);
            tick();
        end
        total++; if (axis_data_count !== 12'd2048) $display("FAIL full_count: got %0d expected 2048", axis_data_count); else passed++;
        total++; if (s_axis_tready !== 1'b0) $display("FAIL full_sready: got %b expected 0", s_axis_tready); else passed++;
`ifdef DP_RAM_STATUS_EN
        total++; if (full !== 1'b1) $display("FAIL full_flag: got %b expected 1", full); else passed++;
`endif
        s_axis_tdata = 8'hEE;
        tick();
        total++; if (axis_data_count !== 12'd2048) $display("FAIL full_drop: got %0d expected 2048", axis_data_count); else passed++;
`ifdef DP_RAM_STATUS_EN
        total++; if (overflow !== 1'b1) $display("FAIL overflow_flag: got %b expected 1", overflow); else passed++;
`endif
        m_axis_tready = 1'b1;
        tick();
        s_axis_tvalid = 1'b0;
        m_axis_tready = 1'b0;
        total++; if (axis_data_count !== 12'd2047) $display("FAIL full_read_count: got %0d expected 2047", axis_data_count); else passed++;
        total++; if (s_axis_tready !== 1'b1) $display("FAIL full_read_sready: got %b expected 1", s_axis_tready); else passed++;
        m_axis_tready = 1'b1;
        for (int i = 1; i < 2048; i++) begin
            total++; if (m_axis_tdata !== 8'(i)) $display("FAIL full_drain[%0d]: got %h expected %h", i, m_axis_tdata, 8'(i)); else passed++;
            tick();
        end
        m_axis_tready = 1'b0;
        total++; if (axis_data_count !== 12'd0 || m_axis_tvalid !== 1'b0) $display("FAIL full_drained: got %0d/%b expected 0/0", axis_data_count, m_axis_tvalid); else passed++;
    endtask

    task automatic test_simultaneous;
        s_axis_tvalid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            s_axis_tdata = 8'(i);
            tick();
        end
        m_axis_tready = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            s_axis_tdata = 8'(i + 10);
            #1;
            total++; if (m_axis_tdata !== 8'(i) || axis_data_count !== 12'd10) $display("FAIL simul[%0d]: got %h/%0d expected %h/10", i, m_axis_tdata, axis_data_count, 8'(i)); else passed++;
            tick();
        end
        s_axis_tvalid = 1'b0;
        for (int k = 0; k < 10; k++) begin
            total++; if (m_axis_tdata !== 8'(3000 + k)) $display("FAIL simul_tail[%0d]: got %h expected %h", k, m_axis_tdata, 8'(3000 + k)); else passed++;
            tick();
        end
        m_axis_tready = 1'b0;
        total++; if (axis_data_count !== 12'd0) $display("FAIL simul_drained: got %0d expected 0", axis_data_count); else passed++;
    endtask

    task automatic test_empty_read;
        m_axis_tready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            total++; if (axis_data_count !== 12'd0 || m_axis_tvalid !== 1'b0) $display("FAIL empty_read[%0d]: got %0d/%b expected 0/0", i, axis_data_count, m_axis_tvalid); else passed++;
        end
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = 8'h3C;
        tick();
        s_axis_tvalid = 1'b0;
        m_axis_tready = 1'b0;
        total++; if (axis_data_count !== 12'd1) $display("FAIL empty_wr_count: got %0d expected 1", axis_data_count); else passed++;
        total++; if (m_axis_tdata !== 8'h3C || m_axis_tvalid !== 1'b1) $display("FAIL empty_wr_data: got %h/%b expected 3c/1", m_axis_tdata, m_axis_tvalid); else passed++;
        m_axis_tready = 1'b1;
        tick();
        m_axis_tready = 1'b0;
        total++; if (axis_data_count !== 12'd0) $display("FAIL empty_final: got %0d expected 0", axis_data_count); else passed++;
    endtask

    initial begin
        passed        = 0;
        total         = 0;
        s_aresetn     = 1'b0;
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = 8'h00;
        m_axis_tready = 1'b0;
        @(negedge s_aclk);
        test_reset();
        test_fwft();
        test_burst();
        test_full();
        test_simultaneous();
        test_empty_read();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/dp_ram_fifo.md
Name: dp_ram_fifo

Overview:
- Single-clock AXI4-Stream FIFO backed by a dual-port RAM, with first-word-fall-through (FWFT) output and an occupancy count.
- Used as the packet buffer in the Ethernet TX packer.
- User bytes enter on the slave stream. The packer waits for a byte count, then drains the FIFO through the master stream.

Parameters:
- DATA_W, 8: stream data width in bits.
- ADDR_W, 11: RAM address width. DEPTH = 2**ADDR_W = 2048 entries.
- CNT_W, ADDR_W+1 (12): width of axis_data_count, so 0..DEPTH is representable.

Ports:
- s_aclk, input, 1: sole clock; all logic on the rising edge.
- s_aresetn, input, 1: reset, asynchronous, active-low.
- s_axis_tvalid, input, 1: write data valid.
- s_axis_tready, output, 1: FIFO can accept a word.
- s_axis_tdata, input, DATA_W: write data.
- m_axis_tvalid, output, 1: FIFO holds at least one word.
- m_axis_tready, input, 1: consumer pops the head word.
- m_axis_tdata, output, DATA_W: head-of-FIFO word (FWFT).
- axis_data_count, output, CNT_W: current occupancy.

Behaviour:
- Reset (asserted at any time, mid-transfer included): write pointer, read pointer and count go to 0 immediately.
  - s_axis_tready=1 and m_axis_tvalid=0 while s_aresetn is low and after release.
  - axis_data_count=0.
  - RAM contents are not reset. m_axis_tdata is don't-care while m_axis_tvalid=0.
- Write: s_axis_tready = (count != DEPTH). A word is stored when s_axis_tvalid && s_axis_tready.
  - Stored at mem[wr_ptr]; wr_ptr increments and wraps modulo DEPTH.
- Read: m_axis_tvalid = (count != 0). m_axis_tdata = mem[rd_ptr], combinational from RAM.
  - The word is popped when m_axis_tvalid && m_axis_tready; rd_ptr increments and wraps modulo DEPTH.
  - m_axis_tready while empty is ignored: no pointer or count change.
- Count: registered.
  - +1 on write only; -1 on read only.
  - Unchanged on simultaneous write and read, or on neither.
  - Always equals wr_ptr - rd_ptr, with full distinguished by count.
- Latency: a word written at edge N appears on m_axis_tdata, with m_axis_tvalid=1, after edge N. There is no same-cycle bypass when empty.
- Empty with simultaneous write and ready: write accepted, nothing popped; count becomes 1.
- Full (count=2048): s_axis_tready=0 and writes are dropped by the handshake.
  - A read in the same cycle frees space; s_axis_tready rises the next cycle.
- Ordering: strict FIFO; no loss or duplication across pointer wrap.
- Data is held stable at the head while m_axis_tvalid=1 and m_axis_tready=0.

Optional Feature:
- Macro DP_RAM_STATUS_EN. When defined, three extra outputs exist:
  - full, 1 bit: count == DEPTH.
  - empty, 1 bit: count == 0.
  - overflow, 1 bit, sticky: set on any cycle with s_axis_tvalid=1 while full; cleared only by reset.
- When undefined, these ports and their logic are absent; all other behaviour is identical.

Decomposition:
- Shared package dp_ram_pkg holds:
  - default constants DP_RAM_DATA_W=8 and DP_RAM_ADDR_W=11;
  - a function computing DEPTH from the address width.
- One natural sub-module, dp_ram_mem: simple dual-port RAM.
  - Synchronous write port: we, waddr, wdata.
  - Asynchronous read port: raddr, rdata.
  - No reset.
- Pointer, count and handshake control lives in the top.

Test Plan:
- Reset state: assert s_aresetn=0 mid-stream with count=5 → immediately count=0, m_axis_tvalid=0, s_axis_tready=1.
- Basic FWFT: write 0xA5 with m_axis_tready=0 → next cycle m_axis_tvalid=1, m_axis_tdata=0xA5, count=1. Pulse m_axis_tready → count=0, m_axis_tvalid=0.
- Burst and order: write bytes 0x00..0xFF (256 words), then drain with m_axis_tready=1 → output 0x00..0xFF in order; count peaks at 256 and returns to 0.
- Full boundary: write 2048 words → count=2048, s_axis_tready=0. Drive a 2049th write → not stored. One read → s_axis_tready=1 next cycle; count=2047.
- Simultaneous read/write: with count=10, hold both handshakes for 3000 cycles with incrementing data → count stays 10 throughout; output sequence is contiguous across pointer wrap at 2048.
- Empty read ignored: m_axis_tready=1 with count=0 for 5 cycles → count stays 0 and pointers unchanged. A subsequent write of 0x3C is read back as 0x3C.
